// File: rtl/pipeline_pc_predictor.sv
`default_nettype none
//============================================================================
// Module   : pipeline_pc_predictor
// Purpose  : Fetch-stage program-counter unit. Owns the PC register, predicts
//            taken control flow with a direct-mapped branch target buffer
//            (BTB) of 2-bit saturating counters, and redirects fetch when the
//            EX stage resolves a branch/jump differently from the prediction.
//
// Build option:
//   PC_PRED_EN  defined   -> BTB present, dynamic prediction.
//               undefined -> no BTB storage; static not-taken prediction
//                            (o_pred_taken = 0, o_pred_target = o_PC + 1).
//
// Parameters:
//   PC_W         word-address width of the PC (byte address bits [PC_W+1:2]),
//                supported range 17..32
//   BTB_ENTRIES  BTB depth, power of two, >= 2
//   RESET_PC     word address loaded on reset
//
// Ports:
//   i_clk, i_rst             clock (rising edge), async active-high reset
//   i_stall                  hold the PC (IF stall)
//   o_PC                     current fetch word address
//   o_pred_taken/_target     prediction for the instruction at o_PC
//   i_res_valid              EX resolves a control instruction this cycle
//   i_res_PC                 PC+1 of the resolving instruction
//   i_res_Imm, i_res_adr_JR  immediate/index field, JR register value
//   i_res_zero/J/Jr/beq/bne  ALU zero flag and decode flags
//   i_res_pred_taken/_target prediction carried down the pipe
//   o_flush                  mispredict: squash IF/ID, PC redirected next edge
//   o_mispred_cnt            wrapping mispredict counter
//
// Revision : 1.0 - initial release
//============================================================================
module pipeline_pc_predictor #(
  parameter int              PC_W        = 30,
  parameter int              BTB_ENTRIES = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_stall,
  output logic [PC_W-1:0] o_PC,
  output logic            o_pred_taken,
  output logic [PC_W-1:0] o_pred_target,
  input  logic            i_res_valid,
  input  logic [PC_W-1:0] i_res_PC,
  input  logic [25:0]     i_res_Imm,
  input  logic [31:0]     i_res_adr_JR,
  input  logic            i_res_zero,
  input  logic            i_res_J,
  input  logic            i_res_Jr,
  input  logic            i_res_beq,
  input  logic            i_res_bne,
  input  logic            i_res_pred_taken,
  input  logic [PC_W-1:0] i_res_pred_target,
  output logic            o_flush,
  output logic [15:0]     o_mispred_cnt
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = PC_W - IDX_W;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     mispred_cnt_q, mispred_cnt_d;

  // --------------------------------------------------------------------------
  // Sequential fetch address. The BTB is looked up with PC+1 so that fetch
  // and resolve index the table with the same quantity (i_res_PC is PC+1).
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] pc_plus1;
  assign pc_plus1 = pc_q + PC_W'(1);

  // --------------------------------------------------------------------------
  // Resolve: actual direction and target of the instruction in EX
  // --------------------------------------------------------------------------
  logic [PC_W-1:0] tgt_j;
  logic [PC_W-1:0] tgt_jr;
  logic [PC_W-1:0] tgt_br;
  logic [PC_W-1:0] br_offset;
  logic [PC_W-1:0] res_target;
  logic [PC_W-1:0] redirect_pc;
  logic            res_taken;
  logic            mispredict;
  logic            unused_jr_bits;

  // J: region bits of PC+1 above the 26-bit index field are kept.
  generate
    if (PC_W > 26) begin : g_jtgt_region
      assign tgt_j = {i_res_PC[PC_W-1:26], i_res_Imm};
    end else begin : g_jtgt_index
      assign tgt_j = i_res_Imm[PC_W-1:0];
    end
  endgenerate

  // JR: register holds a byte address; drop the two byte-offset bits.
  generate
    if (PC_W == 30) begin : g_jrtgt_exact
      assign tgt_jr = i_res_adr_JR[31:2];
    end else if (PC_W > 30) begin : g_jrtgt_zext
      assign tgt_jr = {{(PC_W-30){1'b0}}, i_res_adr_JR[31:2]};
    end else begin : g_jrtgt_trunc
      assign tgt_jr = i_res_adr_JR[PC_W+1:2];
    end
  endgenerate

  // Byte-offset bits of the JR register never reach the word-address PC.
  assign unused_jr_bits = ^i_res_adr_JR[1:0];

  // Conditional branch: PC+1 plus sign-extended 16-bit word offset.
  assign br_offset = {{(PC_W-16){i_res_Imm[15]}}, i_res_Imm[15:0]};
  assign tgt_br    = i_res_PC + br_offset;

  assign res_taken = i_res_J | i_res_Jr
                   | (i_res_beq &  i_res_zero)
                   | (i_res_bne & ~i_res_zero);

  always_comb begin
    res_target = tgt_br;
    if (i_res_J) begin
      res_target = tgt_j;
    end else if (i_res_Jr) begin
      res_target = tgt_jr;
    end
  end

  // A target comparison only matters when both sides agree on "taken";
  // a not-taken prediction carries a fall-through target that is irrelevant.
  assign mispredict = i_res_valid &
                      ((res_taken != i_res_pred_taken) |
                       (res_taken & i_res_pred_taken &
                        (res_target != i_res_pred_target)));

  // Not-taken redirect resumes at the fall-through of the resolving branch.
  assign redirect_pc = res_taken ? res_target : i_res_PC;

  // --------------------------------------------------------------------------
  // Prediction
  // --------------------------------------------------------------------------
  logic            pred_taken;
  logic [PC_W-1:0] pred_target;

`ifdef PC_PRED_EN
  // Valid bits are reset; tag/target/counter storage is not, since a clear
  // valid bit masks whatever the arrays hold.
  logic [BTB_ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]       btb_tag_q    [BTB_ENTRIES];
  logic [PC_W-1:0]        btb_target_q [BTB_ENTRIES];
  logic [1:0]             btb_ctr_q    [BTB_ENTRIES];

  // Lookup side (fetch)
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  assign lk_idx = pc_plus1[IDX_W-1:0];
  assign lk_tag = pc_plus1[PC_W-1:IDX_W];
  assign lk_hit = btb_valid_q[lk_idx] & (btb_tag_q[lk_idx] == lk_tag);

  assign pred_taken  = lk_hit & btb_ctr_q[lk_idx][1];
  assign pred_target = pred_taken ? btb_target_q[lk_idx] : pc_plus1;

  // Update side (resolve). JR targets come from a register and are not
  // stable per PC, so JR never trains the table.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic             up_en;
  logic             up_wr_ctr;
  logic             up_wr_meta;
  logic [1:0]       up_ctr_d;

  assign up_idx = i_res_PC[IDX_W-1:0];
  assign up_tag = i_res_PC[PC_W-1:IDX_W];
  assign up_hit = btb_valid_q[up_idx] & (btb_tag_q[up_idx] == up_tag);
  assign up_en  = i_res_valid & (i_res_J | i_res_beq | i_res_bne) & ~i_res_Jr;

  // Counter is written on every hit and on a taken allocation; tag, target
  // and valid are written on every taken update (on a hit the tag rewrite is
  // a no-op, on a miss it allocates over whatever lived in the slot).
  assign up_wr_ctr  = up_en & (up_hit | res_taken);
  assign up_wr_meta = up_en & res_taken;

  always_comb begin
    up_ctr_d = 2'b10;  // fresh allocation starts weakly taken
    if (up_hit) begin
      up_ctr_d = btb_ctr_q[up_idx];
      if (res_taken) begin
        if (btb_ctr_q[up_idx] != 2'b11) begin
          up_ctr_d = btb_ctr_q[up_idx] + 2'd1;
        end
      end else begin
        if (btb_ctr_q[up_idx] != 2'b00) begin
          up_ctr_d = btb_ctr_q[up_idx] - 2'd1;
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      btb_valid_q <= '0;
    end else if (up_wr_meta) begin
      btb_valid_q[up_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (up_wr_ctr) begin
      btb_ctr_q[up_idx] <= up_ctr_d;
    end
    if (up_wr_meta) begin
      btb_tag_q[up_idx]    <= up_tag;
      btb_target_q[up_idx] <= res_target;
    end
  end
`else
  // Static not-taken: always fetch the next sequential word.
  assign pred_taken  = 1'b0;
  assign pred_target = pc_plus1;
`endif

  // --------------------------------------------------------------------------
  // Next PC: redirect > stall > prediction
  // --------------------------------------------------------------------------
  always_comb begin
    pc_d = pred_target;
    if (i_stall) begin
      pc_d = pc_q;
    end
    if (mispredict) begin
      pc_d = redirect_pc;
    end
  end

  always_comb begin
    mispred_cnt_d = mispred_cnt_q;
    if (mispredict) begin
      mispred_cnt_d = mispred_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      pc_q          <= RESET_PC;
      mispred_cnt_q <= '0;
    end else begin
      pc_q          <= pc_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_PC          = pc_q;
  assign o_pred_taken  = pred_taken;
  assign o_pred_target = pred_target;
  assign o_flush       = mispredict;
  assign o_mispred_cnt = mispred_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_pc_predictor.sv
`default_nettype none
//============================================================================
// Module   : tb_pipeline_pc_predictor
// Purpose  : Self-checking bench for pipeline_pc_predictor: directed vector
//            table, hand-written multi-cycle sequences and randomized
//            resolves, all checked against a behavioural reference model.
//            Follows the PC_PRED_EN build option of the design.
// Revision : 1.0 - initial release
//============================================================================
module tb_pipeline_pc_predictor;

  localparam int              PC_W = 30;
  localparam int              ENT  = 16;
  localparam logic [PC_W-1:0] RPC  = 30'h100;
`ifdef PC_PRED_EN
  localparam bit PRED = 1'b1;
`else
  localparam bit PRED = 1'b0;
`endif
  localparam int OP_NONE = 0, OP_J = 1, OP_JR = 2, OP_BEQ = 3, OP_BNE = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            stall;
  logic            t_v;
  logic [PC_W-1:0] t_rpc;
  logic [25:0]     t_imm;
  logic [31:0]     t_adr;
  logic            t_zero, t_J, t_Jr, t_beq, t_bne, t_pt;
  logic [PC_W-1:0] t_ptgt;
  logic [PC_W-1:0] o_pc, o_ptgt;
  logic            o_pt, o_fl;
  logic [15:0]     o_cnt;

  pipeline_pc_predictor #(.PC_W(PC_W), .BTB_ENTRIES(ENT), .RESET_PC(RPC)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall),
    .o_PC(o_pc), .o_pred_taken(o_pt), .o_pred_target(o_ptgt),
    .i_res_valid(t_v), .i_res_PC(t_rpc), .i_res_Imm(t_imm), .i_res_adr_JR(t_adr),
    .i_res_zero(t_zero), .i_res_J(t_J), .i_res_Jr(t_Jr), .i_res_beq(t_beq),
    .i_res_bne(t_bne), .i_res_pred_taken(t_pt), .i_res_pred_target(t_ptgt),
    .o_flush(o_fl), .o_mispred_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- model
  typedef struct {
    bit              v;
    int unsigned     tag;
    logic [PC_W-1:0] tgt;
    int              ctr;
  } entry_t;

  entry_t          m_btb [ENT];
  logic [PC_W-1:0] m_pc;
  int unsigned     m_cnt;

  function automatic void model_reset();
    m_pc  = RPC;
    m_cnt = 0;
    for (int i = 0; i < ENT; i++) m_btb[i].v = 1'b0;
  endfunction

  function automatic bit actual_taken();
    return t_J || t_Jr || (t_beq && t_zero) || (t_bne && !t_zero);
  endfunction

  function automatic logic [PC_W-1:0] actual_target();
    int off;
    if (t_J)  return ((t_rpc >> 26) << 26) | PC_W'(t_imm);
    if (t_Jr) return PC_W'(t_adr >> 2);
    off = int'($signed(t_imm[15:0]));
    return t_rpc + PC_W'(off);
  endfunction

  function automatic void model_predict(output bit pt, output logic [PC_W-1:0] pg);
    logic [PC_W-1:0] nx;
    int unsigned     idx;
    nx  = m_pc + PC_W'(1);
    idx = int'(nx % ENT);
    pt  = PRED && m_btb[idx].v && (m_btb[idx].tag == int'(nx / ENT)) && (m_btb[idx].ctr >= 2);
    pg  = pt ? m_btb[idx].tgt : nx;
  endfunction

  function automatic bit model_flush();
    bit tk;
    tk = actual_taken();
    return t_v && ((tk != t_pt) || (tk && t_pt && actual_target() != t_ptgt));
  endfunction

  task automatic check_model();
    bit pt; logic [PC_W-1:0] pg;
    model_predict(pt, pg);
    chk("pc", 64'(o_pc), 64'(m_pc));
    chk("pred_taken", 64'(o_pt), 64'(pt));
    chk("pred_target", 64'(o_ptgt), 64'(pg));
    chk("flush", 64'(o_fl), 64'(model_flush()));
    chk("mispred_cnt", 64'(o_cnt), 64'(m_cnt % 65536));
  endtask

  // Advance one clock (from 4 ns after an edge to 1 ns after the next one),
  // applying the resolve/fetch rules to the model state.
  task automatic tick();
    bit pt, fl, tk; logic [PC_W-1:0] pg, tg;
    int unsigned idx; bit hit;
    model_predict(pt, pg);
    fl = model_flush();
    tk = actual_taken();
    tg = actual_target();
    @(posedge clk);
    if (fl)          m_pc = tk ? tg : t_rpc;
    else if (!stall) m_pc = pg;
    if (fl) m_cnt++;
    if (PRED && t_v && (t_J || t_beq || t_bne) && !t_Jr) begin
      idx = int'(t_rpc % ENT);
      hit = m_btb[idx].v && (m_btb[idx].tag == int'(t_rpc / ENT));
      if (hit) begin
        m_btb[idx].ctr = tk ? ((m_btb[idx].ctr < 3) ? m_btb[idx].ctr + 1 : 3)
                            : ((m_btb[idx].ctr > 0) ? m_btb[idx].ctr - 1 : 0);
        if (tk) m_btb[idx].tgt = tg;
      end else if (tk) begin
        m_btb[idx].v   = 1'b1;
        m_btb[idx].tag = int'(t_rpc / ENT);
        m_btb[idx].tgt = tg;
        m_btb[idx].ctr = 2;
      end
    end
    #1;
  endtask

  task automatic drive(bit st, int op, bit z, logic [PC_W-1:0] rp, logic [25:0] im,
                       logic [31:0] ad, bit p, logic [PC_W-1:0] pg);
    stall  = st;
    t_v    = (op != OP_NONE);
    t_J    = (op == OP_J);
    t_Jr   = (op == OP_JR);
    t_beq  = (op == OP_BEQ);
    t_bne  = (op == OP_BNE);
    t_zero = z;
    t_rpc  = rp;
    t_imm  = im;
    t_adr  = ad;
    t_pt   = p;
    t_ptgt = pg;
  endtask

  // ---------------------------------------------------------------- vectors
  typedef struct {
    bit              st;
    int              op;
    bit              z;
    logic [PC_W-1:0] rp;
    logic [25:0]     im;
    logic [31:0]     ad;
    bit              p;
    logic [PC_W-1:0] pg;
    logic [PC_W-1:0] e_pc;
    bit              e_pt;
    logic [PC_W-1:0] e_pg;
    bit              e_fl;
    logic [15:0]     e_cnt;
  } vec_t;

  function automatic vec_t row(bit st, int op, bit z, logic [PC_W-1:0] rp, logic [25:0] im,
                               logic [31:0] ad, bit p, logic [PC_W-1:0] pg,
                               logic [PC_W-1:0] e_pc, bit e_pt, logic [PC_W-1:0] e_pg,
                               bit e_fl, logic [15:0] e_cnt);
    vec_t r;
    r.st = st; r.op = op; r.z = z; r.rp = rp; r.im = im; r.ad = ad; r.p = p; r.pg = pg;
    r.e_pc = e_pc; r.e_pt = e_pt; r.e_pg = e_pg; r.e_fl = e_fl; r.e_cnt = e_cnt;
    return r;
  endfunction

  vec_t tbl [13];

  initial begin
    // Reset-time sequential fetch, first beq mispredict, stall, stall+JR
    // redirect, a correctly predicted J, then the return to 0x104.
    tbl[0]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h100, 0, 'h101, 0, 0);
    tbl[1]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h101, 0, 'h102, 0, 0);
    tbl[2]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h102, 0, 'h103, 0, 0);
    tbl[3]  = row(0, OP_BEQ, 1, 'h105, 26'hFFFA, 0, 0, 0, 'h103, 0, 'h104, 1, 0);
    tbl[4]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h0FF, 0, 'h100, 0, 1);
    tbl[5]  = row(1, OP_NONE, 0, 0, 0, 0, 0, 0, 'h100, 0, 'h101, 0, 1);
    tbl[6]  = row(1, OP_NONE, 0, 0, 0, 0, 0, 0, 'h100, 0, 'h101, 0, 1);
    tbl[7]  = row(1, OP_JR, 0, 0, 0, 32'h400, 0, 0, 'h100, 0, 'h101, 1, 1);
    tbl[8]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h100, 0, 'h101, 0, 2);
    tbl[9]  = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h101, 0, 'h102, 0, 2);
    tbl[10] = row(0, OP_J, 0, 'h200, 26'h50, 0, 1, 'h50, 'h102, 0, 'h103, 0, 2);
    tbl[11] = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h103, 0, 'h104, 0, 2);
    tbl[12] = row(0, OP_NONE, 0, 0, 0, 0, 0, 0, 'h104, PRED,
                  PRED ? 30'h0FF : 30'h105, 0, 2);

    // ------------------------------------------------------------ reset
    rst = 1'b1;
    drive(0, OP_NONE, 0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset pc", 64'(o_pc), 64'(RPC));
    chk("reset pred_taken", 64'(o_pt), 64'd0);
    chk("reset pred_target", 64'(o_ptgt), 64'(RPC + 30'd1));
    chk("reset flush", 64'(o_fl), 64'd0);
    chk("reset cnt", 64'(o_cnt), 64'd0);
    rst = 1'b0;

    // ------------------------------------------------------------ table
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].st, tbl[i].op, tbl[i].z, tbl[i].rp, tbl[i].im, tbl[i].ad, tbl[i].p, tbl[i].pg);
      #3;
      chk($sformatf("vec%0d pc", i), 64'(o_pc), 64'(tbl[i].e_pc));
      chk($sformatf("vec%0d pred_taken", i), 64'(o_pt), 64'(tbl[i].e_pt));
      chk($sformatf("vec%0d pred_target", i), 64'(o_ptgt), 64'(tbl[i].e_pg));
      chk($sformatf("vec%0d flush", i), 64'(o_fl), 64'(tbl[i].e_fl));
      chk($sformatf("vec%0d cnt", i), 64'(o_cnt), 64'(tbl[i].e_cnt));
      check_model();
      tick();
    end

    // ------------------------------------- beq trained then resolved not-taken
    drive(0, OP_BEQ, 0, 'h105, 26'hFFFA, 0, 1, 'h0FF);
    #3;
    chk("nt1 flush", 64'(o_fl), 64'd1);
    check_model();
    tick();
    chk("nt1 redirect pc", 64'(o_pc), 64'h105);
    #3;
    check_model();
    tick();
    drive(0, OP_J, 0, 'h3F3, 26'h104, 0, 0, 0);
    #3;
    check_model();
    tick();
    drive(0, OP_NONE, 0, 0, 0, 0, 0, 0);
    chk("refetch pc", 64'(o_pc), 64'h104);
    chk("refetch pred_taken", 64'(o_pt), 64'd0);
    chk("refetch pred_target", 64'(o_ptgt), 64'h105);
    #3;
    check_model();
    tick();

    // ------------------------------------------------------------ random
    for (int c = 0; c < 3000; c++) begin
      int op;
      logic [25:0] im;
      op = ($urandom_range(0, 99) < 40) ? int'($urandom_range(1, 4)) : OP_NONE;
      if (op == OP_J) im = 26'(RPC + 30'($urandom_range(0, 63)));
      else            im = 26'(16'($urandom_range(0, 64) - 32));
      drive($urandom_range(0, 3) == 0, op, 1'($urandom_range(0, 1)),
            RPC + 30'($urandom_range(0, 47)), im,
            32'((RPC + 30'($urandom_range(0, 63))) << 2),
            1'($urandom_range(0, 1)), RPC + 30'($urandom_range(0, 63)));
      if ($urandom_range(0, 1) == 1) t_ptgt = actual_target();
      #3;
      check_model();
      tick();
    end

    // -------------------------------------------------- async mid-cycle reset
    drive(0, OP_NONE, 0, 0, 0, 0, 0, 0);
    #1;
    rst = 1'b1;
    #1;
    chk("async rst pc", 64'(o_pc), 64'(RPC));
    chk("async rst cnt", 64'(o_cnt), 64'd0);
    chk("async rst pred_taken", 64'(o_pt), 64'd0);
    chk("async rst pred_target", 64'(o_ptgt), 64'(RPC + 30'd1));
    model_reset();
    @(posedge clk);
    #1;
    chk("rst held pc", 64'(o_pc), 64'(RPC));
    rst = 1'b0;

    // ---------------------------------- 65536 mispredicts, last to 0x3FFFFFFF
    for (int i = 0; i < 65536; i++) begin
      drive($urandom_range(0, 3) == 0, OP_JR, 0, 0, 0,
            (i == 65535) ? 32'hFFFF_FFFC : $urandom, 0, 0);
      #3;
      if (i == 65535) chk("cnt pre-wrap", 64'(o_cnt), 64'hFFFF);
      check_model();
      tick();
    end
    drive(0, OP_NONE, 0, 0, 0, 0, 0, 0);
    chk("cnt wrapped", 64'(o_cnt), 64'd0);
    chk("pc top", 64'(o_pc), 64'h3FFF_FFFF);
    #3;
    check_model();
    tick();
    chk("pc wrap", 64'(o_pc), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_pc_predictor.md
# pipeline_pc_predictor

Fetch-stage program-counter unit for the pipelined core: owns the PC register, predicts taken control flow with a direct-mapped branch target buffer (BTB) of 2-bit counters, and redirects fetch when EX resolves a branch/jump differently from the prediction. It generalises the combinational next-PC/PCSrc logic into a parametrised, stateful unit between IF and EX; resolved target arithmetic (J, JR, beq/bne) is unchanged.

## Interface
Parameters:
- PC_W, 30, word-address width of the PC (byte address bits [PC_W+1:2])
- BTB_ENTRIES, 16, BTB depth; power of two, ≥2; IDX_W = log2(BTB_ENTRIES)
- RESET_PC, 0, word address loaded on reset

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_stall  in  1  hold PC (IF stall)
- o_PC  out  PC_W  current fetch word address
- o_pred_taken  out  1  prediction for instruction at o_PC
- o_pred_target  out  PC_W  predicted target; equals o_PC+1 when not taken
- i_res_valid  in  1  EX resolves a control instruction this cycle
- i_res_PC  in  PC_W  PC+1 of the resolving instruction
- i_res_Imm  in  26  instruction immediate/index field
- i_res_adr_JR  in  32  register value for JR
- i_res_zero, i_res_J, i_res_Jr, i_res_beq, i_res_bne  in  1 each  ALU zero and decode flags
- i_res_pred_taken  in  1  prediction carried down the pipe
- i_res_pred_target  in  PC_W  predicted target carried down the pipe
- o_flush  out  1  mispredict: squash IF/ID, PC redirected next edge
- o_mispred_cnt  out  16  mispredict count, wraps

## Operation
- Actual taken: J | Jr | (beq & zero) | (bne & ~zero).
- Actual target: J → {i_res_PC[PC_W-1:26], i_res_Imm}; Jr → i_res_adr_JR[31:2]; branch → i_res_PC + sign-extended i_res_Imm[15:0], modulo 2^PC_W.
- Mispredict (only when i_res_valid): taken ≠ i_res_pred_taken, or both taken and target ≠ i_res_pred_target.
- Redirect target: actual target if taken, else i_res_PC.
- Next PC priority: redirect > i_stall (hold) > o_pred_target. PC+1 wraps modulo 2^PC_W.
- BTB lookup on o_PC+1 (consistent with i_res_PC indexing): index = low IDX_W bits, tag = upper PC_W−IDX_W bits. Hit = valid & tag match; o_pred_taken = hit & counter[1].
- BTB update when i_res_valid & (J | beq | bne); Jr never updates:
  - Hit: counter +1 saturating at 3 if taken, −1 saturating at 0 if not; target rewritten if taken.
  - Miss, taken: allocate (overwrite) entry: valid, tag, target, counter = 2.
  - Miss, not taken: no write.
- Updates occur regardless of i_stall.
- o_mispred_cnt increments on each o_flush; wraps 0xFFFF → 0.

## Timing
- Reset: o_PC = RESET_PC, all BTB valid bits 0 (so o_pred_taken = 0, o_pred_target = RESET_PC+1), o_mispred_cnt = 0, o_flush = 0 (no resolve). Tag/target/counter arrays not reset.
- o_pred_taken/o_pred_target combinational from PC register and BTB, same cycle as o_PC.
- o_flush combinational in the resolve cycle; new PC visible one edge later (latency 1), overriding stall.
- Same-index BTB write and lookup in one cycle: lookup sees pre-write contents; write visible next cycle.
- Reset asserted mid-operation: PC, valid bits and counter clear immediately, independent of clock.

## Configuration
- PC_PRED_EN defined: BTB present, behaviour as above.
- PC_PRED_EN undefined: no BTB storage; o_pred_taken = 0, o_pred_target = o_PC+1 always (static not-taken); every taken resolve flushes; PC, redirect, flush, counter unchanged.

## Test plan
- Reset with RESET_PC=0x100, release, no stall → o_PC 0x100, 0x101, 0x102…; o_pred_taken 0; o_mispred_cnt 0.
- Resolve beq, i_res_PC=0x105, Imm=0xFFFA, zero=1, pred_taken=0 → o_flush 1 that cycle, o_PC=0xFF next edge, o_mispred_cnt=1; when o_PC=0x104 again, o_pred_taken=1, o_pred_target=0xFF.
- Same branch resolved not-taken twice after allocation → counter 2→1→0; third fetch of 0x104 predicts not-taken; first not-taken resolve flushes to 0x105.
- Jr to adr_JR=0x0000_0400 with pred_taken=0 → o_flush, o_PC=0x100; BTB unchanged.
- i_stall high and mispredict in same cycle → redirect wins; stall alone holds o_PC for every stalled cycle.
- o_mispred_cnt preset via 65536 mispredicts → wraps to 0; o_PC=0x3FFFFFFF with no prediction → next o_PC=0.
